// File: rtl/dt2_wb_stage.sv
// MEM/WB pipeline register with load formatting, misaligned/illegal-load trap, result mux and retire counter.
// Latency one cycle from the M inputs; StallW holds the W register, FlushW bubbles it (flush beats stall).
module dt2_wb_stage #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallW,
    input  logic               FlushW,
    input  logic               ValidM,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic [2:0]         Funct3M,
    input  logic [4:0]         RdM,
    input  logic [XLEN-1:0]    ALUResultM,
    input  logic [XLEN-1:0]    ReadDataM,
    input  logic [XLEN-1:0]    PCPlus4M,
    input  logic [XLEN-1:0]    ImmExtM,
    output logic [XLEN-1:0]    ResultW,
    output logic [4:0]         RdW,
    output logic               RegWriteW,
    output logic               RetireValidW,
    output logic               RetireTrapW,
    output logic [ORDER_W-1:0] RetireOrderW
);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
    } wb_reg_t;

    wb_reg_t            wb_d, wb_q;
    logic [ORDER_W-1:0] order_d, order_q;

    logic [OFF_W-1:0]   off;
    logic [XLEN-1:0]    lane;
    logic [XLEN-1:0]    load_val;
    logic               misaligned;
    logic               illegal;
    logic               trap;

    always_comb begin
        wb_d = wb_q;
        if (FlushW) begin
            wb_d.valid = 1'b0;
        end else if (!StallW) begin
            wb_d.valid      = ValidM;
            wb_d.reg_write  = RegWriteM;
            wb_d.result_src = ResultSrcM;
            wb_d.funct3     = Funct3M;
            wb_d.rd         = RdM;
            wb_d.alu_result = ALUResultM;
            wb_d.read_data  = ReadDataM;
            wb_d.pc_plus4   = PCPlus4M;
            wb_d.imm_ext    = ImmExtM;
        end
    end

    always_comb begin
        order_d = order_q;
        if (RetireValidW) order_d = order_q + ORDER_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q    <= '0;
            order_q <= '0;
        end else begin
            wb_q    <= wb_d;
            order_q <= order_d;
        end
    end

    // Shift the addressed byte down to lane 0 so every size extracts from the bottom.
    always_comb begin
        off        = wb_q.alu_result[OFF_W-1:0];
        lane       = wb_q.read_data >> {off, 3'b000};
        load_val   = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (wb_q.funct3)
            3'b000: load_val = XLEN'($signed(lane[7:0]));
            3'b100: load_val = XLEN'(lane[7:0]);
            3'b001: begin
                load_val   = XLEN'($signed(lane[15:0]));
                misaligned = off[0];
            end
            3'b101: begin
                load_val   = XLEN'(lane[15:0]);
                misaligned = off[0];
            end
            3'b010: begin
                load_val   = XLEN'($signed(lane[31:0]));
                misaligned = (off[1:0] != 2'b00);
            end
            3'b110: begin
                load_val   = XLEN'(lane[31:0]);
                misaligned = (off[1:0] != 2'b00);
                illegal    = (XLEN == 32);
            end
            3'b011: begin
                load_val   = lane;
                misaligned = (off != '0);
                illegal    = (XLEN == 32);
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (wb_q.result_src)
            2'b00:   ResultW = wb_q.alu_result;
            2'b01:   ResultW = load_val;
            2'b10:   ResultW = wb_q.pc_plus4;
            default: ResultW = wb_q.imm_ext;
        endcase
    end

    assign trap         = wb_q.valid & (wb_q.result_src == 2'b01) & (misaligned | illegal);
    assign RetireTrapW  = trap;
    assign RegWriteW    = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0) & ~trap;
    assign RetireValidW = wb_q.valid & ~StallW;
    assign RetireOrderW = order_q;
    assign RdW          = wb_q.rd;
endmodule

// File: tb/tb_dt2_wb_stage.sv
// Directed bench: a 32-bit and a 64-bit (4-bit order counter) stage run in lockstep on shared stimulus.
module tb_dt2_wb_stage;
    logic        clk = 1'b0;
    logic        reset, StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [63:0] alu_m, rdat_m, pc_m, imm_m;

    logic [31:0] res32;
    logic [4:0]  rd32;
    logic        rw32, rv32, tr32;
    logic [63:0] ord32;
    logic [63:0] res64;
    logic [4:0]  rd64;
    logic        rw64, rv64, tr64;
    logic [3:0]  ord64;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dt2_wb_stage #(.XLEN(32), .ORDER_W(64)) u32 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALUResultM(alu_m[31:0]), .ReadDataM(rdat_m[31:0]), .PCPlus4M(pc_m[31:0]),
        .ImmExtM(imm_m[31:0]), .ResultW(res32), .RdW(rd32), .RegWriteW(rw32),
        .RetireValidW(rv32), .RetireTrapW(tr32), .RetireOrderW(ord32)
    );

    dt2_wb_stage #(.XLEN(64), .ORDER_W(4)) u64 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALUResultM(alu_m), .ReadDataM(rdat_m), .PCPlus4M(pc_m), .ImmExtM(imm_m),
        .ResultW(res64), .RdW(rd64), .RegWriteW(rw64), .RetireValidW(rv64),
        .RetireTrapW(tr64), .RetireOrderW(ord64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rdat,
                         input logic [63:0] pc, input logic [63:0] imm);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3; RdM = rd;
        alu_m = alu; rdat_m = rdat; pc_m = pc; imm_m = imm;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
        drive(0, 0, 2'b00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);
        tick(); tick();
        chk("rst_result", 64'(res32), 64'h0);
        chk("rst_rd", 64'(rd32), 64'h0);
        chk("rst_regwrite", 64'(rw32), 64'h0);
        chk("rst_retire", 64'(rv32), 64'h0);
        chk("rst_trap", 64'(tr32), 64'h0);
        chk("rst_order", ord32, 64'h0);
        reset = 1'b0;

        // Three ALU ops
        drive(1, 1, 2'b00, 3'b000, 5'd5, 64'd1, 64'h0, 64'h0, 64'h0); tick();
        chk("alu0_result", 64'(res32), 64'd1);
        chk("alu0_rd", 64'(rd32), 64'd5);
        chk("alu0_regwrite", 64'(rw32), 64'd1);
        chk("alu0_order", ord32, 64'd0);
        drive(1, 1, 2'b00, 3'b000, 5'd6, 64'd2, 64'h0, 64'h0, 64'h0); tick();
        chk("alu1_result", 64'(res32), 64'd2);
        chk("alu1_regwrite", 64'(rw32), 64'd1);
        chk("alu1_order", ord32, 64'd1);
        drive(1, 1, 2'b00, 3'b000, 5'd7, 64'd3, 64'h0, 64'h0, 64'h0); tick();
        chk("alu2_result", 64'(res32), 64'd3);
        chk("alu2_regwrite", 64'(rw32), 64'd1);
        chk("alu2_order", ord32, 64'd2);

        // LB across all four byte offsets, then LBU
        drive(1, 1, 2'b01, 3'b000, 5'd8, 64'h1000, 64'h80FF7F01, 64'h0, 64'h0); tick();
        chk("lb_off0", 64'(res32), 64'h00000001);
        drive(1, 1, 2'b01, 3'b000, 5'd8, 64'h1001, 64'h80FF7F01, 64'h0, 64'h0); tick();
        chk("lb_off1", 64'(res32), 64'h0000007F);
        drive(1, 1, 2'b01, 3'b000, 5'd8, 64'h1002, 64'h80FF7F01, 64'h0, 64'h0); tick();
        chk("lb_off2", 64'(res32), 64'hFFFFFFFF);
        drive(1, 1, 2'b01, 3'b000, 5'd8, 64'h1003, 64'h80FF7F01, 64'h0, 64'h0); tick();
        chk("lb_off3", 64'(res32), 64'hFFFFFF80);
        chk("lb_off3_order", ord32, 64'd6);
        drive(1, 1, 2'b01, 3'b100, 5'd8, 64'h1003, 64'h80FF7F01, 64'h0, 64'h0); tick();
        chk("lbu_off3", 64'(res32), 64'h00000080);

        // LH aligned, then misaligned LH traps
        drive(1, 1, 2'b01, 3'b001, 5'd8, 64'h1002, 64'h80011234, 64'h0, 64'h0); tick();
        chk("lh_off2", 64'(res32), 64'hFFFF8001);
        chk("lh_off2_order", ord32, 64'd8);
        drive(1, 1, 2'b01, 3'b001, 5'd8, 64'h1001, 64'h80011234, 64'h0, 64'h0); tick();
        chk("lh_mis_trap", 64'(tr32), 64'd1);
        chk("lh_mis_regwrite", 64'(rw32), 64'd0);
        chk("lh_mis_retire", 64'(rv32), 64'd1);
        chk("lh_mis_order", ord32, 64'd9);

        // Stall for three cycles with different M inputs waiting
        drive(1, 1, 2'b00, 3'b000, 5'd9, 64'hAA, 64'h0, 64'h0, 64'h0); tick();
        chk("trap_counted_order", ord32, 64'd10);
        StallW = 1'b1;
        drive(1, 1, 2'b00, 3'b000, 5'd10, 64'hBB, 64'h0, 64'h0, 64'h0);
        #1;
        chk("stall_retire_now", 64'(rv32), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_result", i), 64'(res32), 64'hAA);
            chk($sformatf("stall%0d_rd", i), 64'(rd32), 64'd9);
            chk($sformatf("stall%0d_retire", i), 64'(rv32), 64'd0);
            chk($sformatf("stall%0d_order", i), ord32, 64'd10);
        end
        StallW = 1'b0;
        #1;
        chk("unstall_retire", 64'(rv32), 64'd1);
        tick();
        chk("unstall_result", 64'(res32), 64'hBB);
        chk("unstall_order", ord32, 64'd11);

        // Flush and stall together: bubble, nothing retires
        FlushW = 1'b1; StallW = 1'b1;
        drive(1, 1, 2'b00, 3'b000, 5'd11, 64'hCC, 64'h0, 64'h0, 64'h0); tick();
        FlushW = 1'b0; StallW = 1'b0;
        #1;
        chk("flush_retire", 64'(rv32), 64'd0);
        chk("flush_regwrite", 64'(rw32), 64'd0);
        chk("flush_order", ord32, 64'd11);

        // PC+4 to x0, then LUI immediate
        drive(1, 1, 2'b10, 3'b000, 5'd0, 64'h0, 64'h0, 64'h104, 64'h0); tick();
        chk("pc4_result", 64'(res32), 64'h104);
        chk("pc4_x0_regwrite", 64'(rw32), 64'd0);
        chk("pc4_order", ord32, 64'd11);
        drive(1, 1, 2'b11, 3'b000, 5'd3, 64'h0, 64'h0, 64'h0, 64'h12345000); tick();
        chk("imm_result", 64'(res32), 64'h12345000);
        chk("imm_regwrite", 64'(rw32), 64'd1);

        // 64-bit loads
        drive(1, 1, 2'b01, 3'b011, 5'd4, 64'h2000, 64'h8877665544332211, 64'h0, 64'h0); tick();
        chk("ld64_result", res64, 64'h8877665544332211);
        chk("ld64_regwrite", 64'(rw64), 64'd1);
        chk("ld64_trap", 64'(tr64), 64'd0);
        chk("ld32_illegal_trap", 64'(tr32), 64'd1);
        chk("ld64_order", 64'(ord64), 64'd13);
        drive(1, 1, 2'b01, 3'b110, 5'd4, 64'h2000, 64'h0000000080000000, 64'h0, 64'h0); tick();
        chk("lwu64_result", res64, 64'h0000000080000000);
        drive(1, 1, 2'b01, 3'b010, 5'd4, 64'h2004, 64'h8000000000000000, 64'h0, 64'h0); tick();
        chk("lw64_off4_result", res64, 64'hFFFFFFFF80000000);
        chk("lw64_order", 64'(ord64), 64'd15);
        drive(1, 1, 2'b00, 3'b000, 5'd1, 64'h55, 64'h0, 64'h0, 64'h0); tick();
        chk("order64_wrap", 64'(ord64), 64'd0);
        chk("order32_nowrap", ord32, 64'd16);

        // Misaligned LW and funct3=111 both trap
        drive(1, 1, 2'b01, 3'b010, 5'd2, 64'h1002, 64'h11223344, 64'h0, 64'h0); tick();
        chk("lw32_mis_trap", 64'(tr32), 64'd1);
        chk("lw32_mis_regwrite", 64'(rw32), 64'd0);
        drive(1, 1, 2'b01, 3'b111, 5'd2, 64'h1000, 64'h11223344, 64'h0, 64'h0); tick();
        chk("f3_111_trap32", 64'(tr32), 64'd1);
        chk("f3_111_trap64", 64'(tr64), 64'd1);
        chk("f3_111_order", ord32, 64'd18);

        // Reset mid-stream with a valid op in W
        drive(1, 1, 2'b00, 3'b000, 5'd5, 64'h77, 64'h0, 64'h0, 64'h0); tick();
        reset = 1'b1; tick();
        chk("midrst_regwrite", 64'(rw32), 64'd0);
        chk("midrst_retire", 64'(rv32), 64'd0);
        chk("midrst_order32", ord32, 64'd0);
        chk("midrst_order64", 64'(ord64), 64'd0);
        chk("midrst_result", 64'(res32), 64'd0);
        reset = 1'b0;
        tick();
        chk("postrst_result", 64'(res32), 64'h77);
        chk("postrst_order", ord32, 64'd0);
        tick();
        chk("postrst_order_inc", ord32, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dt2_wb_stage.md
Name: dt2_wb_stage

Overview:
Parametrised writeback stage for the pipelined RV32I/RV64I core. It contains the MEM/WB pipeline register with stall and flush, and formats load data: byte/half/word/double extraction with sign or zero extension by funct3 and address offset. It detects misaligned loads and selects the register-file write value from four sources. It also gates register writes, keeps a retirement counter, and drives forwarded writeback data back to the execute and decode stages.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ORDER_W, 64, width of retirement order counter
OFF_W, log2(XLEN/8), byte-offset bits used for load alignment (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
StallW  in  1  hold MEM/WB register contents
FlushW  in  1  insert bubble into MEM/WB register
ValidM  in  1  instruction in memory stage is real (not a bubble)
RegWriteM  in  1  instruction writes rd
ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
Funct3M  in  3  load size/sign
RdM  in  5  destination register
ALUResultM  in  XLEN  ALU result / load address
ReadDataM  in  XLEN  naturally aligned memory word containing the access
PCPlus4M  in  XLEN  return address
ImmExtM  in  XLEN  extended immediate
ResultW  out  XLEN  register-file write data and forward value
RdW  out  5  destination register
RegWriteW  out  1  qualified register write enable
RetireValidW  out  1  instruction retires this cycle
RetireTrapW  out  1  retiring instruction is a misaligned or illegal load
RetireOrderW  out  ORDER_W  count of instructions retired before this one

Behaviour:
- Register update on rising edge of clk, with priority reset > FlushW > StallW > load:
  - reset: valid_q=0; all data fields=0; order counter=0.
  - FlushW: valid_q=0; data fields don't-care; counter unaffected by the flush itself.
  - StallW: all fields hold.
  - Otherwise: capture every M input into the W register; valid_q=ValidM.
- FlushW and StallW asserted together: the flush wins.
- Outputs are combinational from the W register, so latency is one cycle from the M inputs.
- Output values after reset: ResultW=0 (ALU source, zero data), RdW=0, RegWriteW=0, RetireValidW=0, RetireTrapW=0, RetireOrderW=0.
- Load offset: off = ALUResult_q[OFF_W-1:0].
- Load formatting, applied when ResultSrc_q=01:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: half at off, sign-extended; misaligned if off[0]=1.
  - 101 LHU: half at off, zero-extended; misaligned if off[0]=1.
  - 010 LW: word at off, sign-extended to XLEN; misaligned if off[1:0]!=0.
  - 110 LWU: word at off, zero-extended; XLEN=64 only.
  - 011 LD: full word; XLEN=64 only; misaligned if off!=0.
  - Any funct3 illegal for the configured XLEN (011/110 at XLEN=32, 111 always) is treated as a trap.
- Byte lanes are little-endian: byte k = ReadData_q[8k+7:8k].
- ResultW by source: 00 ALUResult_q; 01 formatted load; 10 PCPlus4_q; 11 ImmExt_q.
- trap = valid_q & (ResultSrc_q==01) & (misaligned | illegal funct3). RetireTrapW=trap.
- RegWriteW = valid_q & RegWrite_q & (Rd_q!=0) & ~trap. A trap never writes the register file. A write to x0 is always suppressed.
- RetireValidW = valid_q & ~StallW. A stalled instruction retires only once, in the cycle the stall drops.
- RetireOrderW shows the current counter value. The counter increments by 1 on each clock edge where RetireValidW=1 and reset=0. Trapping instructions count as retired. The counter wraps modulo 2^ORDER_W.
- reset asserted mid-operation: the W register is invalidated and the counter cleared in the same edge. No retirement is reported on that edge.
- RdW=Rd_q is always output, even when invalid; consumers qualify it with RegWriteW.

Test Plan:
- Reset then 3 valid ALU ops (RdM=5,6,7, ALUResultM=1,2,3) -> ResultW=1,2,3 on successive cycles; RetireOrderW=0,1,2; RegWriteW=1 each.
- LB with ReadDataM=0x80FF7F01, off=0..3 -> ResultW=0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU at off=3 -> 0x00000080.
- LH at off=2 with ReadDataM=0x8001_1234 -> 0xFFFF8001. LH at off=1 -> RetireTrapW=1, RegWriteW=0, RetireOrderW still increments.
- StallW held 3 cycles on a valid ALU op -> outputs stable, RetireValidW=0 during stall, exactly one retirement after release. FlushW+StallW together -> bubble, RetireValidW=0.
- ResultSrcM=10 with PCPlus4M=0x104 and RdM=0 -> ResultW=0x104, RegWriteW=0. ResultSrcM=11 with ImmExtM=0x12345000 -> ResultW=0x12345000.
- XLEN=64, ORDER_W=4: LD at off=0 passes full word; LWU of 0x8000_0000 -> 0x0000_0000_8000_0000; 17 retirements -> RetireOrderW wraps 15->0; reset mid-stream -> order 0, RegWriteW=0 next cycle.
